// File: rtl/edge_event_detector_pkg.sv
// Shared definitions for the edge event detector: detect-mode encodings,
// legal parameter ranges and small helpers used by the channel logic.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;
  localparam int DEB_MIN   = 1;
  localparam int DEB_MAX   = 65535;

  // A level change qualifies as an event when the mode asks for that direction.
  function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
    case (edge_mode_e'(mode))
      MODE_RISE: return new_level;
      MODE_FALL: return !new_level;
      MODE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Debounce counter width; a single bit is kept even when no filtering is done.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/edge_event_detector_channel.sv
// One input channel: synchroniser chain, debounce filter, edge qualification
// against the per-channel mode, and the sticky pending flag.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       edge_pulse,
  output logic       pending
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   update;
  logic                   qualified;

  assign s_p1 = sync_p0[SYNC_STAGES-1];

  // Level is accepted once the synced value has differed for the full window.
  assign update    = (s_p1 != level) && (cnt_p1 == CNT_LAST);
  assign qualified = update && edge_qualifies(mode, s_p1);

  // Stage 0: metastability chain, bit 0 samples the raw asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], signal_in};
    end
  end

  // Stage 1: debounce counter and accepted level; pulse marks a qualified update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p1     <= '0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= qualified;
      if (s_p1 == level) begin
        cnt_p1 <= '0;
      end else if (update) begin
        cnt_p1 <= '0;
        level  <= s_p1;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  // Sticky flag: a new event outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else begin
      pending <= qualified | (pending & ~clr);
    end
  end

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: WIDTH independent channels, each with its
// own mode, pending flag and interrupt enable, merged into a single irq.
module edge_event_detector
  import edge_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   edge_pulse,
  output logic [WIDTH-1:0]   pending,
  output logic               irq
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
      DEBOUNCE_CYCLES < DEB_MIN || DEBOUNCE_CYCLES > DEB_MAX) begin : g_param_check
    $error("edge_event_detector: parameter out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .signal_in  (signal_in[i]),
      .mode       (mode[2*i +: 2]),
      .clr        (clr[i]),
      .level      (level[i]),
      .edge_pulse (edge_pulse[i]),
      .pending    (pending[i])
    );
  end

  // Stage 2: registered interrupt from enabled pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(pending & irq_en);
    end
  end

endmodule

// File: tb/tb_edge_event_detector.sv
// Bench for edge_event_detector: directed vector table, multi-cycle debounce
// and reset sequences, and a randomized run against a sliding-window model.
module tb_edge_event_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instance A: 4 channels, SYNC=2, DEB=1 (vector table)
  logic [3:0] a_sig = '0, a_clr = '0, a_en = '0;
  logic [7:0] a_mode = 8'b00_11_01_10;
  logic [3:0] a_level, a_pulse, a_pend;
  logic       a_irq;
  edge_event_detector #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .signal_in(a_sig), .mode(a_mode), .clr(a_clr),
    .irq_en(a_en), .level(a_level), .edge_pulse(a_pulse), .pending(a_pend), .irq(a_irq));

  // Instance B: 1 channel, SYNC=2, DEB=4, both edges
  logic [0:0] b_sig = '0, b_clr = '0, b_en = '0;
  logic [1:0] b_mode = 2'b11;
  logic [0:0] b_level, b_pulse, b_pend;
  logic       b_irq;
  edge_event_detector #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .signal_in(b_sig), .mode(b_mode), .clr(b_clr),
    .irq_en(b_en), .level(b_level), .edge_pulse(b_pulse), .pending(b_pend), .irq(b_irq));

  // Instance C: 1 channel, SYNC=2, DEB=8, rising only, irq enabled
  logic [0:0] c_sig = '0, c_clr = '0, c_en = 1'b1;
  logic [1:0] c_mode = 2'b01;
  logic [0:0] c_level, c_pulse, c_pend;
  logic       c_irq;
  edge_event_detector #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .signal_in(c_sig), .mode(c_mode), .clr(c_clr),
    .irq_en(c_en), .level(c_level), .edge_pulse(c_pulse), .pending(c_pend), .irq(c_irq));

  // Instance R: 3 channels, SYNC=3, DEB=3 (randomized)
  localparam int R_SYNC = 3;
  localparam int R_DEB  = 3;
  localparam int HL     = R_SYNC + R_DEB;
  logic [2:0] r_sig = '0, r_clr = '0, r_en = '0;
  logic [5:0] r_mode = 6'b11_11_11;
  logic [2:0] r_level, r_pulse, r_pend;
  logic       r_irq;
  edge_event_detector #(.WIDTH(3), .SYNC_STAGES(R_SYNC), .DEBOUNCE_CYCLES(R_DEB)) u_r (
    .clk(clk), .rst(rst), .signal_in(r_sig), .mode(r_mode), .clr(r_clr),
    .irq_en(r_en), .level(r_level), .edge_pulse(r_pulse), .pending(r_pend), .irq(r_irq));

  typedef struct {
    logic [3:0] sig;
    logic [3:0] clr;
    logic [3:0] en;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] pnd;
    logic       irq;
  } vec_t;
  vec_t tbl [21];

  // Reference model state for instance R
  logic [HL-1:0] hist [3];
  logic [2:0]    m_lvl, m_pend, e_pls;
  logic          e_irq;
  logic [R_DEB-1:0] win;
  logic [1:0]    md;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            sig      clr      en       lvl      pls      pnd      irq
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 4'b0010, 1'b0};
    tbl[4]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[10] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[11] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0100, 4'b0101, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0101, 1'b0};
    tbl[14] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 1'b0};
    tbl[15] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1};
    tbl[17] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1};
    tbl[18] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0};
    tbl[19] = '{4'b1000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0};
    tbl[20] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_level", 32'(a_level), 32'd0);
    chk("rst_a_pulse", 32'(a_pulse), 32'd0);
    chk("rst_a_pend",  32'(a_pend),  32'd0);
    chk("rst_a_irq",   32'(a_irq),   32'd0);
    chk("rst_c_pend",  32'(c_pend),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table on instance A
    for (int i = 0; i < 21; i++) begin
      a_sig = tbl[i].sig;
      a_clr = tbl[i].clr;
      a_en  = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_level", i), 32'(a_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_pulse", i), 32'(a_pulse), 32'(tbl[i].pls));
      chk($sformatf("tbl%0d_pend",  i), 32'(a_pend),  32'(tbl[i].pnd));
      chk($sformatf("tbl%0d_irq",   i), 32'(a_irq),   32'(tbl[i].irq));
    end

    // Instance B: 3-cycle glitch is filtered out
    for (int i = 0; i < 16; i++) begin
      b_sig = (i < 3) ? 1'b1 : 1'b0;
      step();
      chk("glitch_pulse", 32'(b_pulse), 32'd0);
      chk("glitch_level", 32'(b_level), 32'd0);
    end
    // Instance B: 4-cycle high gives a rise pulse at edge 5 and a fall pulse at edge 9
    for (int i = 0; i < 16; i++) begin
      b_sig = (i < 4) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("deb4_pulse_e%0d", i), 32'(b_pulse), 32'((i == 5) || (i == 9)));
      chk($sformatf("deb4_level_e%0d", i), 32'(b_level), 32'((i >= 5) && (i < 9)));
    end
    chk("deb4_pend", 32'(b_pend), 32'd1);
    chk("deb4_irq_masked", 32'(b_irq), 32'd0);

    // Randomized run on instance R against the window model
    for (int c = 0; c < 3; c++) hist[c] = '0;
    m_lvl  = '0;
    m_pend = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(2) == 0) r_sig[c] = ~r_sig[c];
      if ($urandom_range(31) == 0) r_mode = 6'($urandom);
      r_clr = 3'($urandom) & 3'($urandom) & 3'($urandom);
      if ($urandom_range(7) == 0) r_en = 3'($urandom);
      step();
      e_irq = |(m_pend & r_en);
      for (int c = 0; c < 3; c++) begin
        hist[c] = {hist[c][HL-2:0], r_sig[c]};
        win = hist[c][HL-1:R_SYNC];
        e_pls[c] = 1'b0;
        if ((win == '0 || win == '1) && (win[0] != m_lvl[c])) begin
          m_lvl[c] = win[0];
          md = r_mode[2*c +: 2];
          e_pls[c] = (md == 2'b11) || (md == 2'b01 && m_lvl[c]) || (md == 2'b10 && !m_lvl[c]);
        end
        m_pend[c] = e_pls[c] | (m_pend[c] & ~r_clr[c]);
      end
      chk("rnd_level", 32'(r_level), 32'(m_lvl));
      chk("rnd_pulse", 32'(r_pulse), 32'(e_pls));
      chk("rnd_pend",  32'(r_pend),  32'(m_pend));
      chk("rnd_irq",   32'(r_irq),   32'(e_irq));
    end

    // Instance C: first rising event sets pending and irq
    c_sig = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("c_rise_pulse_e%0d", i), 32'(c_pulse), 32'(i == 9));
      chk($sformatf("c_rise_level_e%0d", i), 32'(c_level), 32'(i >= 9));
      chk($sformatf("c_rise_irq_e%0d", i),   32'(c_irq),   32'(i >= 10));
    end
    c_sig = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("c_fall_no_pulse", 32'(c_pulse), 32'd0);
    end
    chk("c_fall_level", 32'(c_level), 32'd0);
    chk("c_fall_pend",  32'(c_pend),  32'd1);
    chk("c_fall_irq",   32'(c_irq),   32'd1);

    // Instance C: reset while the count sits at 5
    c_sig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("c_mid_pulse", 32'(c_pulse), 32'd0);
      chk("c_mid_level", 32'(c_level), 32'd0);
    end
    #2 rst = 1'b0;
    #1;
    chk("c_async_level", 32'(c_level), 32'd0);
    chk("c_async_pulse", 32'(c_pulse), 32'd0);
    chk("c_async_pend",  32'(c_pend),  32'd0);
    chk("c_async_irq",   32'(c_irq),   32'd0);
    repeat (2) step();
    chk("c_inrst_pend",  32'(c_pend),  32'd0);
    chk("c_inrst_level", 32'(c_level), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("c_rel_pulse_e%0d", i), 32'(c_pulse), 32'(i == 9));
      chk($sformatf("c_rel_level_e%0d", i), 32'(c_level), 32'(i >= 9));
      chk($sformatf("c_rel_pend_e%0d", i),  32'(c_pend),  32'(i >= 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
